// File: rtl/pipe_stage_latch.sv
// pipe_stage_latch: configurable inter-stage pipeline register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//
// Captures a valid bit, a control bundle and a datapath bundle each rising edge.
// Action priority per edge: freeze > flush > stall > advance.
//
// Ports:
//   CLK        in   clock, rising edge
//   nRST       in   asynchronous active-low reset
//   freeze     in   global hold, all state including counters holds
//   flush      in   insert bubble: valid_q=0, ctrl_q=CTRL_SAFE, data_q loads data_d
//   stall      in   local hold of valid_q/ctrl_q/data_q
//   valid_d    in   upstream entry valid
//   ctrl_d     in   upstream control bundle [CTRL_W]
//   data_d     in   upstream datapath bundle [DATA_W]
//   valid_q    out  registered valid
//   ctrl_q     out  registered control [CTRL_W]
//   data_q     out  registered datapath [DATA_W]
//   perf_clr   in   synchronous counter clear
//   stall_cnt  out  saturating count of stall cycles [CNT_W]
//   bubble_cnt out  saturating count of flush bubbles [CNT_W]
//
// Optional feature macro: PIPE_STAGE_PERF_EN enables the performance counters.
// Without it the counter ports exist but read zero and perf_clr is ignored.
module pipe_stage_latch #(
    parameter int                CTRL_W    = 16,
    parameter int                DATA_W    = 128,
    parameter logic [CTRL_W-1:0] CTRL_SAFE = '0,
    parameter int                CNT_W     = 32
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              freeze,
    input  logic              flush,
    input  logic              stall,
    input  logic              valid_d,
    input  logic [CTRL_W-1:0] ctrl_d,
    input  logic [DATA_W-1:0] data_d,
    output logic              valid_q,
    output logic [CTRL_W-1:0] ctrl_q,
    output logic [DATA_W-1:0] data_q,
    input  logic              perf_clr,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  bubble_cnt
);
    // flush and invalid advance both force the safe control, keeping valid_q=0 -> ctrl_q==CTRL_SAFE
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= 1'b0;
            ctrl_q  <= CTRL_SAFE;
            data_q  <= '0;
        end else if (!freeze) begin
            if (flush) begin
                valid_q <= 1'b0;
                ctrl_q  <= CTRL_SAFE;
                data_q  <= data_d;
            end else if (!stall) begin
                valid_q <= valid_d;
                ctrl_q  <= valid_d ? ctrl_d : CTRL_SAFE;
                data_q  <= data_d;
            end
        end
    end

`ifdef PIPE_STAGE_PERF_EN
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            stall_cnt  <= '0;
            bubble_cnt <= '0;
        end else if (!freeze) begin
            if (perf_clr) begin
                stall_cnt  <= '0;
                bubble_cnt <= '0;
            end else begin
                // a flush overrides stall, so that edge is counted as a bubble only
                if (stall && !flush && stall_cnt != '1)
                    stall_cnt <= stall_cnt + 1'b1;
                if (flush && bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + 1'b1;
            end
        end
    end
`else
    logic unused_perf_clr;
    assign unused_perf_clr = perf_clr;
    assign stall_cnt       = '0;
    assign bubble_cnt      = '0;
`endif
endmodule

// File: tb/tb_pipe_stage_latch.sv
// tb_pipe_stage_latch: directed self-checking bench for pipe_stage_latch (CNT_W=4)
module tb_pipe_stage_latch;
`ifdef PIPE_STAGE_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif
    localparam logic [127:0] DA5 = {16{8'hA5}};
    localparam logic [127:0] D5A = {16{8'h5A}};
    localparam logic [127:0] DC3 = {16{8'hC3}};
    localparam logic [127:0] D96 = {16{8'h96}};

    logic         CLK = 1'b0;
    logic         nRST;
    logic         freeze, flush, stall, valid_d, perf_clr;
    logic [15:0]  ctrl_d;
    logic [127:0] data_d;
    logic         valid_q;
    logic [15:0]  ctrl_q;
    logic [127:0] data_q;
    logic [3:0]   stall_cnt, bubble_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    pipe_stage_latch #(.CTRL_W(16), .DATA_W(128), .CTRL_SAFE(16'h0000), .CNT_W(4)) dut (
        .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush(flush), .stall(stall),
        .valid_d(valid_d), .ctrl_d(ctrl_d), .data_d(data_d),
        .valid_q(valid_q), .ctrl_q(ctrl_q), .data_q(data_q),
        .perf_clr(perf_clr), .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
    );

    always #5 CLK = ~CLK;

    // advance one rising edge, then settle away from it
    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [3:0] pc(input logic [3:0] v);
        return PERF ? v : 4'h0;
    endfunction

    task automatic test_reset;
        nRST = 1'b0; freeze = 0; flush = 0; stall = 0; perf_clr = 0;
        valid_d = 1'b1; ctrl_d = 16'hFFFF; data_d = D96;
        step(2);
        n_checks++; if (valid_q !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %h exp 0", valid_q); end
        n_checks++; if (ctrl_q !== 16'h0000) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 0000", ctrl_q); end
        n_checks++; if (data_q !== 128'h0) begin n_fail++; $display("FAIL reset_data: got %h exp 0", data_q); end
        n_checks++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_stall_cnt: got %h exp 0", stall_cnt); end
        n_checks++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL reset_bubble_cnt: got %h exp 0", bubble_cnt); end
        nRST = 1'b1;
        step();
        n_checks++; if (valid_q !== 1'b1) begin n_fail++; $display("FAIL first_edge_valid: got %h exp 1", valid_q); end
        n_checks++; if (ctrl_q !== 16'hFFFF) begin n_fail++; $display("FAIL first_edge_ctrl: got %h exp ffff", ctrl_q); end
        n_checks++; if (data_q !== D96) begin n_fail++; $display("FAIL first_edge_data: got %h exp %h", data_q, D96); end
    endtask

    task automatic test_advance_stall;
        valid_d = 1'b1; ctrl_d = 16'h1234; data_d = DA5;
        step();
        n_checks++; if (data_q !== DA5) begin n_fail++; $display("FAIL adv_data: got %h exp %h", data_q, DA5); end
        stall = 1'b1; ctrl_d = 16'h4321; data_d = D5A;
        step(3);
        n_checks++; if (data_q !== DA5) begin n_fail++; $display("FAIL stall_data: got %h exp %h", data_q, DA5); end
        n_checks++; if (ctrl_q !== 16'h1234) begin n_fail++; $display("FAIL stall_ctrl: got %h exp 1234", ctrl_q); end
        n_checks++; if (valid_q !== 1'b1) begin n_fail++; $display("FAIL stall_valid: got %h exp 1", valid_q); end
        n_checks++; if (stall_cnt !== pc(4'd3)) begin n_fail++; $display("FAIL stall_cnt3: got %h exp %h", stall_cnt, pc(4'd3)); end
    endtask

    task automatic test_flush_priority;
        stall = 1'b1; flush = 1'b1; ctrl_d = 16'h00FF; valid_d = 1'b1;
        step();
        n_checks++; if (ctrl_q !== 16'h0000) begin n_fail++; $display("FAIL flush_ctrl: got %h exp 0000", ctrl_q); end
        n_checks++; if (valid_q !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %h exp 0", valid_q); end
        n_checks++; if (data_q !== D5A) begin n_fail++; $display("FAIL flush_data: got %h exp %h", data_q, D5A); end
        n_checks++; if (bubble_cnt !== pc(4'd1)) begin n_fail++; $display("FAIL flush_bubble_cnt: got %h exp %h", bubble_cnt, pc(4'd1)); end
        n_checks++; if (stall_cnt !== pc(4'd3)) begin n_fail++; $display("FAIL flush_stall_cnt: got %h exp %h", stall_cnt, pc(4'd3)); end
    endtask

    task automatic test_freeze;
        flush = 1'b0; stall = 1'b0; valid_d = 1'b1; ctrl_d = 16'hABCD; data_d = DC3;
        step();
        freeze = 1'b1; flush = 1'b1; stall = 1'b1; perf_clr = 1'b1; ctrl_d = 16'h0F0F; data_d = D96;
        step(2);
        n_checks++; if (valid_q !== 1'b1) begin n_fail++; $display("FAIL freeze_valid: got %h exp 1", valid_q); end
        n_checks++; if (ctrl_q !== 16'hABCD) begin n_fail++; $display("FAIL freeze_ctrl: got %h exp abcd", ctrl_q); end
        n_checks++; if (data_q !== DC3) begin n_fail++; $display("FAIL freeze_data: got %h exp %h", data_q, DC3); end
        n_checks++; if (stall_cnt !== pc(4'd3)) begin n_fail++; $display("FAIL freeze_stall_cnt: got %h exp %h", stall_cnt, pc(4'd3)); end
        n_checks++; if (bubble_cnt !== pc(4'd1)) begin n_fail++; $display("FAIL freeze_bubble_cnt: got %h exp %h", bubble_cnt, pc(4'd1)); end
        freeze = 1'b0; stall = 1'b0; perf_clr = 1'b0;
        step();
        n_checks++; if (valid_q !== 1'b0) begin n_fail++; $display("FAIL unfreeze_valid: got %h exp 0", valid_q); end
        n_checks++; if (ctrl_q !== 16'h0000) begin n_fail++; $display("FAIL unfreeze_ctrl: got %h exp 0000", ctrl_q); end
        n_checks++; if (bubble_cnt !== pc(4'd2)) begin n_fail++; $display("FAIL unfreeze_bubble_cnt: got %h exp %h", bubble_cnt, pc(4'd2)); end
    endtask

    task automatic test_invalid_advance;
        flush = 1'b0; valid_d = 1'b1; ctrl_d = 16'h7777; data_d = DA5;
        step();
        valid_d = 1'b0; ctrl_d = 16'hFFFF; data_d = D5A;
        step();
        n_checks++; if (valid_q !== 1'b0) begin n_fail++; $display("FAIL inv_valid: got %h exp 0", valid_q); end
        n_checks++; if (ctrl_q !== 16'h0000) begin n_fail++; $display("FAIL inv_ctrl: got %h exp 0000", ctrl_q); end
        n_checks++; if (data_q !== D5A) begin n_fail++; $display("FAIL inv_data: got %h exp %h", data_q, D5A); end
    endtask

    task automatic test_saturation;
        stall = 1'b1;
        step(11);
        n_checks++; if (stall_cnt !== pc(4'hE)) begin n_fail++; $display("FAIL sat_pre: got %h exp %h", stall_cnt, pc(4'hE)); end
        step(9);
        n_checks++; if (stall_cnt !== pc(4'hF)) begin n_fail++; $display("FAIL sat_hold: got %h exp %h", stall_cnt, pc(4'hF)); end
        perf_clr = 1'b1;
        step();
        n_checks++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL clr_stall_cnt: got %h exp 0", stall_cnt); end
        n_checks++; if (bubble_cnt !== 4'h0) begin n_fail++; $display("FAIL clr_bubble_cnt: got %h exp 0", bubble_cnt); end
        perf_clr = 1'b0;
        step();
        n_checks++; if (stall_cnt !== pc(4'd1)) begin n_fail++; $display("FAIL post_clr_cnt: got %h exp %h", stall_cnt, pc(4'd1)); end
        stall = 1'b0;
    endtask

    task automatic test_async_reset;
        valid_d = 1'b1; ctrl_d = 16'hBEEF; data_d = DC3;
        step();
        n_checks++; if (ctrl_q !== 16'hBEEF) begin n_fail++; $display("FAIL pre_rst_ctrl: got %h exp beef", ctrl_q); end
        #2 nRST = 1'b0;
        #1;
        n_checks++; if (valid_q !== 1'b0) begin n_fail++; $display("FAIL async_rst_valid: got %h exp 0", valid_q); end
        n_checks++; if (ctrl_q !== 16'h0000) begin n_fail++; $display("FAIL async_rst_ctrl: got %h exp 0000", ctrl_q); end
        n_checks++; if (data_q !== 128'h0) begin n_fail++; $display("FAIL async_rst_data: got %h exp 0", data_q); end
        n_checks++; if (stall_cnt !== 4'h0) begin n_fail++; $display("FAIL async_rst_cnt: got %h exp 0", stall_cnt); end
        step();
        nRST = 1'b1;
    endtask

    initial begin
        test_reset();
        test_advance_stall();
        test_flush_priority();
        test_freeze();
        test_invalid_advance();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
